// File: rtl/fir_pkg.sv
// Shared FIR output-path definitions: default sample width, sample type and
// derived width constants used by the filter and its decimating output buffer.
package fir_pkg;

  localparam int FIR_L     = 12;
  localparam int DECIM_DEF = 4;
  localparam int DEPTH_DEF = 8;

  typedef logic signed [FIR_L-1:0] sample_t;

  localparam int DECIM_S_DEF  = $clog2(DECIM_DEF);
  localparam int FIFO_AW_DEF  = $clog2(DEPTH_DEF);
  localparam int ACC_W_DEF    = FIR_L + DECIM_S_DEF;

endpackage

// File: rtl/fir_decim_buf_fifo.sv
// sync_fifo: show-ahead synchronous FIFO with wrap-bit pointers, used as the
// buffer behind the decimator. A push into a full FIFO is accepted only when a pop frees a slot.
module sync_fifo
  import fir_pkg::*;
#(
  parameter int WIDTH = FIR_L,
  parameter int DEPTH = DEPTH_DEF,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop_req,
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld,
  output logic [AW:0]      level,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             empty;
  logic             do_pop;
  logic             do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop_req && !empty;
  assign do_push = push && (!full || do_pop);

  assign level    = wr_ptr - rd_ptr;
  assign dout_vld = !empty;
  assign dout     = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (!rst && do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/fir_decim_buf.sv
// Decimating output buffer behind the FIR: keeps one sample per DECIM valid inputs
// (or their rounded boxcar average when DECIM_AVG_EN is defined) and queues it in sync_fifo.
module fir_decim_buf
  import fir_pkg::*;
#(
  parameter int L     = FIR_L,
  parameter int DECIM = DECIM_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_vld,
  input  logic signed [L-1:0] x,
  output logic signed [L-1:0] out,
  output logic                out_vld,
  input  logic                out_rdy,
  output logic [AW:0]         level,
  output logic                ovf
);

  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [PW-1:0] LAST = PW'(DECIM - 1);

  logic [PW-1:0]       phase;
  logic                emit;
  logic                pop;
  logic                fifo_full;
  logic signed [L-1:0] d;

  assign emit = in_vld && (phase == LAST);
  assign pop  = out_vld && out_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= '0;
    end else if (in_vld) begin
      phase <= (phase == LAST) ? '0 : phase + 1'b1;
    end
  end

  // A window result is lost only when the FIFO is full and nothing drains this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (emit && fifo_full && !pop) begin
      ovf <= 1'b1;
    end
  end

`ifdef DECIM_AVG_EN
  localparam int S    = $clog2(DECIM);
  localparam int ACCW = L + S;

  logic signed [ACCW-1:0] acc;
  logic signed [ACCW-1:0] acc_sum;

  assign acc_sum = (phase == '0) ? ACCW'(x) : acc + ACCW'(x);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (in_vld) begin
      acc <= acc_sum;
    end
  end

  // Half-up rounding: add half an LSB of the result, then arithmetic shift.
  if (S == 0) begin : g_noround
    assign d = x;
  end else begin : g_round
    localparam logic signed [ACCW:0] HALF = (ACCW+1)'(1) <<< (S - 1);
    logic signed [ACCW:0] rounded;
    logic signed [ACCW:0] shifted;
    assign rounded = (ACCW+1)'(acc_sum) + HALF;
    assign shifted = rounded >>> S;
    assign d       = shifted[L-1:0];
  end
`else
  assign d = x;
`endif

  sync_fifo #(
    .WIDTH (L),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (emit),
    .din      (d),
    .pop_req  (out_rdy),
    .dout     (out),
    .dout_vld (out_vld),
    .level    (level),
    .full     (fifo_full)
  );

endmodule

// File: tb/tb_fir_decim_buf.sv
// Self-checking bench for fir_decim_buf: queue-based window/FIFO model compared every
// cycle, plus directed scenarios with hand-computed results (DECIM_AVG_EN selects averaging).
module tb_fir_decim_buf;
  import fir_pkg::*;

  localparam int L     = 12;
  localparam int DECIM = 4;
  localparam int DEPTH = 8;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_vld = 1'b0;
  sample_t       x = '0;
  sample_t       out;
  logic          out_vld;
  logic          out_rdy = 1'b0;
  logic [AW:0]   level;
  logic          ovf;

  int total = 0;
  int bad   = 0;

  fir_decim_buf #(.L(L), .DECIM(DECIM), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (in_vld),
    .x       (x),
    .out     (out),
    .out_vld (out_vld),
    .out_rdy (out_rdy),
    .level   (level),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  // Reference model: windows collected as lists, FIFO as a queue.
  int  mq[$];
  int  win[$];
  int  popped[$];
  bit  movf    = 0;
  bit  started = 0;
  int  maxlevel = 0;

  function automatic int window_result(input int w[$]);
    int sum, n;
`ifdef DECIM_AVG_EN
    sum = 0;
    foreach (w[i]) sum += w[i];
    n = sum + DECIM / 2;
    if (n >= 0) return n / DECIM;
    return -((-n + DECIM - 1) / DECIM);
`else
    sum = 0;
    n = 0;
    return w[w.size()-1];
`endif
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      win.delete();
      movf    = 0;
      started = 1;
    end else if (started) begin
      if (out_rdy && mq.size() > 0) void'(mq.pop_front());
      if (in_vld) begin
        win.push_back(int'(x));
        if (win.size() == DECIM) begin
          if (mq.size() < DEPTH) mq.push_back(window_result(win));
          else movf = 1;
          win.delete();
        end
      end
    end
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      checkOutput("model out_vld", int'(out_vld), int'(mq.size() != 0));
      checkOutput("model out", int'(out), (mq.size() != 0) ? mq[0] : 0);
      checkOutput("model level", int'(level), mq.size());
      checkOutput("model ovf", int'(ovf), int'(movf));
      if (int'(level) > maxlevel) maxlevel = int'(level);
      if (out_vld && out_rdy) popped.push_back(int'(out));
    end
  end

  task automatic applyStimulus(input logic r, input logic v, input int xv, input logic rdy);
    rst     = r;
    in_vld  = v;
    x       = sample_t'(xv);
    out_rdy = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic checkPopped(input string name, input int idx, input int exp);
    if (popped.size() > idx) checkOutput(name, popped[idx], exp);
    else checkOutput({name, " missing"}, popped.size(), idx + 1);
  endtask

  int t2[8] = '{640, 1217, 1671, 1958, 2047, 1931, 1621, 1148};

  initial begin
    // 1: reset then idle
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 0, 0);
      checkOutput("t1 out_vld", int'(out_vld), 0);
      checkOutput("t1 level", int'(level), 0);
      checkOutput("t1 out", int'(out), 0);
      checkOutput("t1 ovf", int'(ovf), 0);
    end

    // 2: pick of every fourth sample, consumer always ready
    popped.delete();
    maxlevel = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 1, t2[i], 1);
`ifndef DECIM_AVG_EN
      if (i == 3 || i == 7) begin
        checkOutput("t2 out_vld", int'(out_vld), 1);
        checkOutput("t2 out", int'(out), (i == 3) ? 1958 : 1148);
      end
`endif
    end
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1);
    checkOutput("t2 count", popped.size(), 2);
`ifndef DECIM_AVG_EN
    checkPopped("t2 first", 0, 1958);
    checkPopped("t2 second", 1, 1148);
`endif
    checkOutput("t2 maxlevel", maxlevel, 1);

    // 3: stalled consumer, overflow, then drain
    for (int k = 1; k <= 40; k++) begin
      applyStimulus(0, 1, 50 * k, 0);
      if (k == 32) begin
        checkOutput("t3 level full", int'(level), 8);
        checkOutput("t3 ovf before", int'(ovf), 0);
      end
      if (k == 36) checkOutput("t3 ovf after", int'(ovf), 1);
    end
    popped.delete();
    for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 1);
    checkOutput("t3 drained level", int'(level), 0);
    checkOutput("t3 drained count", popped.size(), 8);
`ifndef DECIM_AVG_EN
    for (int i = 0; i < 8; i++) checkPopped("t3 drain order", i, 200 * (i + 1));
`endif
    checkOutput("t3 ovf sticky", int'(ovf), 1);

    // 4: push and pop on the same edge while full
    applyStimulus(1, 0, 0, 0);
    for (int k = 1; k <= 36; k++) applyStimulus(0, 1, 10 * k, (k == 36));
    checkOutput("t4 level", int'(level), 8);
    checkOutput("t4 ovf", int'(ovf), 0);
    popped.delete();
    for (int i = 0; i < 9; i++) applyStimulus(0, 0, 0, 1);
    checkOutput("t4 count", popped.size(), 8);
`ifndef DECIM_AVG_EN
    checkPopped("t4 head", 0, 80);
    checkPopped("t4 newest last", 7, 360);
`endif

    // 5: reset discards a partial window
    applyStimulus(0, 1, 11, 0);
    applyStimulus(0, 1, 22, 0);
    applyStimulus(1, 0, 0, 0);
    popped.delete();
    applyStimulus(0, 1, 10, 1);
    applyStimulus(0, 1, 20, 1);
    applyStimulus(0, 1, 30, 1);
    applyStimulus(0, 1, 40, 1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1);
    checkOutput("t5 count", popped.size(), 1);
`ifdef DECIM_AVG_EN
    checkPopped("t5 value", 0, 25);
`else
    checkPopped("t5 value", 0, 40);
`endif

`ifdef DECIM_AVG_EN
    // 6: averaging windows with rounding at the negative end
    popped.delete();
    applyStimulus(0, 1, 640, 1);
    applyStimulus(0, 1, 1217, 1);
    applyStimulus(0, 1, 1671, 1);
    applyStimulus(0, 1, 1958, 1);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, -2048, 1);
    applyStimulus(0, 1, -1, 1);
    applyStimulus(0, 1, -1, 1);
    applyStimulus(0, 1, -1, 1);
    applyStimulus(0, 1, 0, 1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1);
    checkOutput("t6 count", popped.size(), 3);
    checkPopped("t6 avg1", 0, 1372);
    checkPopped("t6 avg2", 1, -2048);
    checkPopped("t6 avg3", 2, -1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
